lfsr_delay_gen: RTL and testbench

// - Parametrised pseudo-random delay generator for the reaction-time game.
// - A free-running XNOR-feedback LFSR is sampled on start. The sample sets a random

---
 rtl/lfsr_pkg.sv | 51 +++++
 rtl/lfsr_core.sv | 31 +++
 rtl/lfsr_delay_gen.sv | 116 +++++++++++
 tb/tb_lfsr_delay_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, maximal-length tap table and the LFSR step function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Maximal-length XNOR tap masks, bit i set = state[i] feeds the XNOR.
  // Shift direction is towards the MSB with feedback into bit 0.
  localparam logic [32:3][31:0] MAXLEN_TAPS = {
    32'h8020_0003,  // 32
    32'h4800_0000,  // 31
    32'h2000_0029,  // 30
    32'h1400_0000,  // 29
    32'h0900_0000,  // 28
    32'h0400_0013,  // 27
    32'h0200_0023,  // 26
    32'h0120_0000,  // 25
    32'h00E1_0000,  // 24
    32'h0042_0000,  // 23
    32'h0030_0000,  // 22
    32'h0014_0000,  // 21
    32'h0009_0000,  // 20
    32'h0004_0023,  // 19
    32'h0002_0400,  // 18
    32'h0001_2000,  // 17
    32'h0000_D008,  // 16
    32'h0000_6000,  // 15
    32'h0000_2015,  // 14
    32'h0000_100D,  // 13
    32'h0000_0829,  // 12
    32'h0000_0500,  // 11
    32'h0000_0240,  // 10
    32'h0000_0110,  // 9
    32'h0000_00B8,  // 8
    32'h0000_0060,  // 7
    32'h0000_0030,  // 6
    32'h0000_0014,  // 5
    32'h0000_000C,  // 4
    32'h0000_0006   // 3
  };

  // One LFSR step on a 32-bit container; caller truncates to its width.
  // Taps only cover the caller's width, so upper zero bits never feed back.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
    return {s[30:0], ~^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running XNOR LFSR with seed load; an all-ones seed would lock up, so it maps to zero.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = 7,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(MAXLEN_TAPS[WIDTH])
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q, state_d;

  // Seed load wins over stepping; lockup seed is swapped for the reset value.
  always_comb begin
    state_d = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS)));
    if (seed_load) state_d = (seed == '1) ? '0 : seed;
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= '0;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_delay_gen.sv
// Random delay generator: samples the LFSR on start, counts down in ticks, then enables RUN.
module lfsr_delay_gen
  import lfsr_pkg::*;
#(
  parameter int                WIDTH      = 7,
  parameter logic [WIDTH-1:0]  TAPS       = WIDTH'(MAXLEN_TAPS[WIDTH]),
  parameter int                RANGE_BITS = 7,
  parameter int                MIN_DELAY  = 500,
  parameter int                CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic             abort,
  input  logic             tick,
  output logic [WIDTH-1:0] rand_out,
  output logic [CNT_W-1:0] delay_val,
  output logic             busy,
  output logic             done,
  output logic             cenable
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_delay_gen: WIDTH must be in 3..32");
  end
  if (RANGE_BITS < 1 || RANGE_BITS > WIDTH) begin : g_bad_range
    $error("lfsr_delay_gen: RANGE_BITS must be in 1..WIDTH");
  end
  if (MIN_DELAY < 1) begin : g_bad_min
    $error("lfsr_delay_gen: MIN_DELAY must be >= 1");
  end
  if (longint'(MIN_DELAY) + (longint'(1) << RANGE_BITS) - 1 >= (longint'(1) << CNT_W))
  begin : g_bad_cnt
    $error("lfsr_delay_gen: CNT_W too narrow for MIN_DELAY + 2**RANGE_BITS - 1");
  end

  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DELAY);

  logic [WIDTH-1:0] lfsr_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] delay_q, delay_d, arm_delay;
  logic [WIDTH-1:0] rand_q, rand_d;
  logic             done_q, done_d;

  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .state     (lfsr_s)
  );

  // Countdown loaded on an accepted start, from the pre-step LFSR value.
  assign arm_delay = MIN_D + CNT_W'(lfsr_s[RANGE_BITS-1:0]);

  // Next state: abort beats start beats tick; start while ARMED is ignored.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    rand_d  = rand_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = ARMED;
          rand_d  = lfsr_s;
          delay_d = arm_delay;
        end
      end
      ARMED: begin
        if (abort) begin
          state_d = IDLE;
          delay_d = '0;
        end else if (tick) begin
          if (delay_q <= CNT_W'(1)) begin
            state_d = RUN;
            delay_d = '0;
            done_d  = 1'b1;
          end else begin
            delay_d = delay_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        delay_d = '0;
      end
    endcase
  end

  // FSM, countdown and captured-sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      delay_q <= '0;
      rand_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      rand_q  <= rand_d;
      done_q  <= done_d;
    end
  end

  assign rand_out  = rand_q;
  assign delay_val = delay_q;
  assign busy      = (state_q == ARMED);
  assign cenable   = (state_q == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_lfsr_delay_gen.sv
// Directed bench for lfsr_delay_gen with default parameters.
module tb_lfsr_delay_gen;

  localparam int W  = 7;
  localparam int CW = 12;

  logic          clk, rst_n, seed_load, start, abort, tick;
  logic [W-1:0]  seed, rand_out;
  logic [CW-1:0] delay_val;
  logic          busy, done, cenable;
  logic [W-1:0]  lfsr_s;

  int checks, errors, done_cnt;
  logic [W-1:0] m, m_pre;

  lfsr_delay_gen #(
    .WIDTH(7), .TAPS(7'h60), .RANGE_BITS(7), .MIN_DELAY(500), .CNT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .start(start), .abort(abort), .tick(tick),
    .rand_out(rand_out), .delay_val(delay_val), .busy(busy),
    .done(done), .cenable(cenable)
  );

  assign lfsr_s = dut.u_lfsr.state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic          sl;
    logic [W-1:0]  sd;
    logic          st, ab, tk;
    logic [W-1:0]  e_lfsr, e_rand;
    logic [CW-1:0] e_dly;
    logic          e_busy, e_done, e_cen;
  } vec_t;

  vec_t vt[13];

  function automatic logic [W-1:0] mnext(input logic [W-1:0] s);
    return {s[5:0], ~(s[6] ^ s[5])};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [W-1:0] er, input logic [CW-1:0] ed,
                         input logic eb, input logic edn, input logic ec);
    chk({nm, ".rand"},  32'(rand_out),  32'(er));
    chk({nm, ".delay"}, 32'(delay_val), 32'(ed));
    chk({nm, ".busy"},  32'(busy),      32'(eb));
    chk({nm, ".done"},  32'(done),      32'(edn));
    chk({nm, ".cen"},   32'(cenable),   32'(ec));
  endtask

  // Drive one cycle of inputs, wait past the edge, advance the bench LFSR model.
  task automatic step(input logic sl, input logic [W-1:0] sd, input logic st,
                      input logic ab, input logic tk);
    seed_load = sl; seed = sd; start = st; abort = ab; tick = tk;
    m_pre = m;
    @(posedge clk); #1;
    m = sl ? ((sd == 7'h7F) ? 7'h00 : sd) : mnext(m);
    seed_load = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0;
  endtask

  initial begin
    logic [W-1:0]  seq[7];
    logic [W-1:0]  cap;
    logic [CW-1:0] d;
    int n, seen7f, merr, d0;

    checks = 0; errors = 0; done_cnt = 0; m = '0; m_pre = '0;
    rst_n = 1'b0; seed_load = 1'b0; seed = '0; start = 1'b0; abort = 1'b0; tick = 1'b0;

    seq = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7E};
    vt[0]  = '{1'b1, 7'h7F, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 12'd0,   1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h01, 7'h00, 12'd0,   1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 7'h05, 1'b0, 1'b0, 1'b0, 7'h05, 7'h00, 12'd0,   1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h0B, 7'h05, 12'd505, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h17, 7'h05, 12'd505, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h2F, 7'h05, 12'd504, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h5E, 7'h05, 12'd0,   1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h3C, 7'h05, 12'd0,   1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'h78, 7'h3C, 12'd560, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 7'h71, 7'h3C, 12'd0,   1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h63, 7'h3C, 12'd0,   1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h47, 7'h63, 12'd599, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h0E, 7'h63, 12'd0,   1'b0, 1'b0, 1'b0};

    // Reset held across an edge
    #12;
    chk_out("reset", 7'h00, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.lfsr", 32'(lfsr_s), 32'h00);
    #10 rst_n = 1'b1;
    #1 chk("post_rst.lfsr", 32'(lfsr_s), 32'h00);

    // Free-run sequence from zero
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("seq%0d", i), 32'(lfsr_s), 32'(seq[i]));
    end

    // Period: count edges until the state returns to zero
    n = 7; seen7f = 0; merr = 0;
    while (lfsr_s !== 7'h00 && n < 300) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n++;
      if (lfsr_s === 7'h7F) seen7f++;
      if (lfsr_s !== m) merr++;
    end
    chk("period", 32'(n), 32'd127);
    chk("no_lockup_state", 32'(seen7f), 32'd0);
    chk("free_run_model", 32'(merr), 32'd0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 13; i++) begin
      step(vt[i].sl, vt[i].sd, vt[i].st, vt[i].ab, vt[i].tk);
      chk($sformatf("vec%0d.lfsr", i), 32'(lfsr_s), 32'(vt[i].e_lfsr));
      chk_out($sformatf("vec%0d", i), vt[i].e_rand, vt[i].e_dly,
              vt[i].e_busy, vt[i].e_done, vt[i].e_cen);
    end
    chk("table_done_cnt", 32'(done_cnt), 32'd0);

    // Full countdown: seed 05, start, 505 ticks every 4 clocks
    step(1'b1, 7'h05, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk_out("arm05", 7'h05, 12'd505, 1'b1, 1'b0, 1'b0);
    d0 = done_cnt;
    for (int t = 1; t <= 505; t++) begin
      for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      if (t < 505) begin
        chk($sformatf("cd%0d.delay", t), 32'(delay_val), 32'(505 - t));
        chk($sformatf("cd%0d.done", t), 32'(done), 32'd0);
      end
    end
    chk_out("expiry", 7'h05, 12'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_out("run", 7'h05, 12'd0, 1'b0, 1'b0, 1'b1);
    chk("one_done_pulse", 32'(done_cnt - d0), 32'd1);

    // Restart from RUN, then a start while ARMED is ignored
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cap = m_pre;
    d = 12'd500 + 12'(cap);
    chk_out("run_restart", cap, d, 1'b1, 1'b0, 1'b0);
    chk("run_restart.new_rand", 32'(cap != 7'h05), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk_out("armed_start", cap, d, 1'b1, 1'b0, 1'b0);

    // Abort after 100 ticks
    d0 = done_cnt;
    for (int t = 0; t < 100; t++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("tick100.delay", 32'(delay_val), 32'(d - 12'd100));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk_out("abort100", cap, 12'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_out("abort100_idle", cap, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("abort100.no_done", 32'(done_cnt - d0), 32'd0);

    // Abort coinciding with the final tick
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cap = m_pre;
    d = 12'd500 + 12'(cap);
    chk_out("rearm", cap, d, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t < int'(d); t++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("last_tick.delay", 32'(delay_val), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk_out("abort_last", cap, 12'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk_out("abort_last_idle", cap, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("abort_last.no_done", 32'(done_cnt - d0), 32'd0);

    // Asynchronous reset mid-ARMED, between edges
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 7'h00, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.lfsr", 32'(lfsr_s), 32'h00);
    #3 rst_n = 1'b1;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("resume%0d", i), 32'(lfsr_s), 32'(seq[i]));
    end
    chk_out("resume_idle", 7'h00, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.no_done", 32'(done_cnt - d0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
